// File: rtl/arbiter8_ctrl_if.sv
// ============================================================================
// Module      : arbiter8_ctrl_if
// Description : Request/grant bundle between eight requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arbiter8_ctrl_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (output req, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface

`default_nettype wire

// File: rtl/arbiter8_ctrl.sv
// ============================================================================
// Module      : arbiter8_ctrl
// Description : Registered one-hot arbiter for eight requesters with a hold
//               limit, one-cycle turnaround and starvation masking.
//               Define ROUND_ROBIN_EN for rotating priority (fixed otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter8_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  arbiter8_ctrl_if.slave  bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] mask_q, mask_d;
  logic       timeout_q, timeout_d;

  logic [7:0] elig;
  logic [2:0] base;
  logic [2:0] idx;
  logic [2:0] win_id;
  logic       win_found;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  assign base = ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && win_found) begin
      ptr_d = win_id + 3'd1;
    end
  end
`else
  assign base = 3'd0;
`endif

  assign elig = bus.req & ~mask_q;

  // First eligible bit at or above base, wrapping 7 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = base;
    idx       = base;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    mask_d     = mask_q & bus.req;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          gnt_d      = 8'd1 << win_id;
          gnt_id_d   = win_id;
          hold_cnt_d = 8'd0;
        end
      end
      ST_GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          state_d = ST_RELEASE;
          gnt_d   = 8'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Mask set overrides the clear computed above.
          state_d          = ST_RELEASE;
          gnt_d            = 8'd0;
          mask_d[gnt_id_q] = 1'b1;
          timeout_d        = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 8'd0;
      gnt_id_q   <= 3'd0;
      hold_cnt_q <= 8'd0;
      mask_q     <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_arbiter8_ctrl.sv
// ============================================================================
// Module      : tb_arbiter8_ctrl
// Description : Self-checking bench: a default instance and a MAX_HOLD=4
//               instance share one request vector, checked against a
//               cycle model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbiter8_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  int n_assert;
  int n_fail;

  arbiter8_ctrl_if bus_a ();
  arbiter8_ctrl_if bus_b ();

  assign bus_a.req = req;
  assign bus_b.req = req;

  arbiter8_ctrl u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  arbiter8_ctrl #(.MAX_HOLD(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phase: 0 = waiting, 1 = owning the resource, 2 = turnaround
  typedef struct packed {
    logic [7:0] mask;
    logic [2:0] owner;
    logic [7:0] ten;
    logic [1:0] phase;
    logic       to;
    logic [2:0] last;
    logic [2:0] ptr;
  } mstate_t;

  mstate_t ms_a, ms_b;

  function automatic mstate_t step(mstate_t s, logic [7:0] r, int h);
    mstate_t    n;
    logic [7:0] elig;
    int         w;
    int         start;
    n     = s;
    elig  = r & ~s.mask;
    n.mask = s.mask & r;
    n.to  = 1'b0;
    case (s.phase)
      2'd0: begin
`ifdef ROUND_ROBIN_EN
        start = int'(s.ptr);
`else
        start = 0;
`endif
        w = -1;
        for (int i = 0; i < 8; i++) begin
          if (w < 0 && elig[(start + i) % 8]) w = (start + i) % 8;
        end
        if (w >= 0) begin
          n.phase = 2'd1;
          n.owner = 3'(w);
          n.last  = 3'(w);
          n.ten   = 8'd1;
          n.ptr   = 3'((w + 1) % 8);
        end
      end
      2'd1: begin
        if (!r[s.owner]) begin
          n.phase = 2'd2;
        end else if (int'(s.ten) == h) begin
          n.mask[s.owner] = 1'b1;
          n.to            = 1'b1;
          n.phase         = 2'd2;
        end else begin
          n.ten = s.ten + 8'd1;
        end
      end
      default: n.phase = 2'd0;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_a <= '0;
      ms_b <= '0;
    end else begin
      ms_a <= step(ms_a, req, 16);
      ms_b <= step(ms_b, req, 4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("a_gnt",     32'(bus_a.gnt),     32'(ms_a.phase == 2'd1 ? (8'd1 << ms_a.owner) : 8'd0));
    chk("a_gnt_id",  32'(bus_a.gnt_id),  32'(ms_a.last));
    chk("a_busy",    32'(bus_a.busy),    32'(ms_a.phase == 2'd1));
    chk("a_timeout", 32'(bus_a.timeout), 32'(ms_a.to));
    chk("b_gnt",     32'(bus_b.gnt),     32'(ms_b.phase == 2'd1 ? (8'd1 << ms_b.owner) : 8'd0));
    chk("b_gnt_id",  32'(bus_b.gnt_id),  32'(ms_b.last));
    chk("b_busy",    32'(bus_b.busy),    32'(ms_b.phase == 2'd1));
    chk("b_timeout", 32'(bus_b.timeout), 32'(ms_b.to));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp_ids [4];
    int id;
    bit seen;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    req = 8'd0;
    cyc(2);
    chk("rst_gnt",    32'(bus_a.gnt),     32'h0);
    chk("rst_gnt_id", 32'(bus_a.gnt_id),  32'h0);
    chk("rst_busy",   32'(bus_a.busy),    32'h0);
    chk("rst_to",     32'(bus_b.timeout), 32'h0);
    rst = 1'b0;
    cyc(2);

    // Basic grant/release on the default instance
    req = 8'b0000_0100;
    cyc(1);
    chk("basic_gnt",    32'(bus_a.gnt),    32'h04);
    chk("basic_gnt_id", 32'(bus_a.gnt_id), 32'd2);
    cyc(4);
    chk("basic_gnt_5th", 32'(bus_a.gnt), 32'h04);
    req = 8'd0;
    cyc(1);
    chk("basic_rel1", 32'(bus_a.gnt),     32'h0);
    chk("basic_to",   32'(bus_a.timeout), 32'h0);
    cyc(1);
    chk("basic_rel2", 32'(bus_a.gnt), 32'h0);
    cyc(3);

    // Priority / rotation
`ifdef ROUND_ROBIN_EN
    exp_ids = '{1, 5, 7, 1};
`else
    exp_ids = '{1, 1, 1, 1};
`endif
    req = 8'b1010_0010;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        cyc(1);
        seen = bus_a.busy;
      end
      chk("prio_wait_busy", 32'(seen), 32'd1);
      chk("prio_id", 32'(bus_a.gnt_id), 32'(exp_ids[t]));
      id = int'(bus_a.gnt_id);
      req[id] = 1'b0;
      cyc(1);
      req[id] = 1'b1;
    end
    req = 8'd0;
    cyc(5);

    // Timeout on the MAX_HOLD=4 instance
    req = 8'b0000_1000;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("to_gnt_held", 32'(bus_b.gnt), 32'h08);
    end
    cyc(1);
    chk("to_gnt_off", 32'(bus_b.gnt),     32'h0);
    chk("to_pulse",   32'(bus_b.timeout), 32'h1);
    cyc(1);
    chk("to_pulse_end", 32'(bus_b.timeout), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("to_masked", 32'(bus_b.gnt), 32'h0);
    end
    req = 8'd0;
    cyc(1);
    req = 8'b0000_1000;
    cyc(1);
    chk("to_regrant", 32'(bus_b.gnt), 32'h08);
    req = 8'd0;
    cyc(5);

    // Starvation masking
    req = 8'b0000_1001;
    cyc(1);
`ifndef ROUND_ROBIN_EN
    chk("starve_first0", 32'(bus_b.gnt), 32'h01);
`endif
    cyc(4);
`ifndef ROUND_ROBIN_EN
    chk("starve_to0", 32'(bus_b.timeout), 32'h1);
`endif
    cyc(2);
`ifndef ROUND_ROBIN_EN
    chk("starve_then3", 32'(bus_b.gnt), 32'h08);
`endif
    cyc(4);
`ifndef ROUND_ROBIN_EN
    chk("starve_to3", 32'(bus_b.timeout), 32'h1);
`endif
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("starve_both_masked", 32'(bus_b.gnt), 32'h0);
    end
    req = 8'd0;
    cyc(5);

    // Request drops in the cycle the limit is reached
    req = 8'b0000_0100;
    cyc(4);
    chk("coinc_gnt4", 32'(bus_b.gnt), 32'h04);
    req = 8'd0;
    cyc(1);
    chk("coinc_no_to", 32'(bus_b.timeout), 32'h0);
    chk("coinc_rel",   32'(bus_b.gnt),     32'h0);
    req = 8'b0000_0100;
    cyc(2);
    chk("coinc_regrant", 32'(bus_b.gnt), 32'h04);
    req = 8'd0;
    cyc(5);

    // Asynchronous reset mid-tenure
    req = 8'b0100_0000;
    cyc(1);
    chk("arst_pre", 32'(bus_a.gnt), 32'h40);
    cyc(1);
    rst = 1'b1;
    #1;
    chk("arst_gnt",    32'(bus_a.gnt),    32'h0);
    chk("arst_busy",   32'(bus_a.busy),   32'h0);
    chk("arst_gnt_id", 32'(bus_a.gnt_id), 32'h0);
    chk("arst_b_gnt",  32'(bus_b.gnt),    32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("arst_regrant", 32'(bus_a.gnt), 32'h40);
    req = 8'd0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbiter8_ctrl.md
# arbiter8_ctrl

Sequential arbiter that shares one resource among eight requesters. It turns the combinational 8-input priority pick into a registered, one-hot grant with a request/hold handshake, a hold-time limit, and starvation masking. It sits between the requesting units and the shared datapath; the datapath mux select comes from `gnt_id`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per tenure; legal range 2..255; internal hold counter is 8 bits.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req` input, 8 bits: request per requester; a requester holds its bit high for as long as it needs the resource.
- `gnt` output, 8 bits: registered one-hot grant; all zero when no tenure is active.
- `gnt_id` output, 3 bits: binary index of the current grantee; holds its last value when `gnt` is zero.
- `busy` output, 1 bit: high whenever `gnt` is non-zero.
- `timeout` output, 1 bit: one-cycle pulse when a tenure is ended by the hold limit.

## Operation
- States: IDLE, GRANT, RELEASE.
- **IDLE**
  - Eligible requests = `req & ~mask`.
  - If any bit is eligible: pick a winner, register `gnt`/`gnt_id`, clear `hold_cnt`, go to GRANT.
  - If none is eligible: stay in IDLE.
- **GRANT**
  - `gnt` = one-hot of `gnt_id`; `busy`=1.
  - `hold_cnt` increments every GRANT cycle.
  - If `req[gnt_id]`==0: normal release, go to RELEASE.
  - Else if `hold_cnt`==MAX_HOLD-1: forced release, set `mask[gnt_id]`, pulse `timeout` in the following cycle, go to RELEASE.
  - Else stay in GRANT.
- **RELEASE**
  - `gnt`=0 and `busy`=0 for exactly one cycle (the bus turnaround).
  - Then go to IDLE.
- **Mask**
  - `mask[k]` clears in any cycle where `req[k]`==0.
  - A timed-out requester must drop its request before it can win again.
  - If setting and clearing a mask bit fall in the same cycle, the set wins.
- **Winner selection**: fixed or rotating, per Configuration.
- **Reset values**: state IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `mask`=0, `hold_cnt`=0, rotation pointer=0.

## Timing
- **Grant latency**: `req` sampled high in IDLE at edge n gives `gnt` high after edge n (visible in cycle n+1).
- **Release**: `req[gnt_id]` seen low at edge m means `gnt`=0 from cycle m+1 (RELEASE) and cycle m+2 (IDLE). The next grant is visible at cycle m+3 at the earliest.
- **Maximum tenure**: `gnt` is high for at most MAX_HOLD consecutive cycles.
- **Timeout pulse**: `timeout` is high only during the RELEASE cycle that follows a forced release.
- **Simultaneous events**:
  - If `req[gnt_id]` drops in the same cycle the limit is reached, it is a normal release: no timeout, no mask.
  - Requests from other requesters that arrive during GRANT or RELEASE are not visible until IDLE.
- **Reset mid-tenure**: `gnt`, `busy` and `timeout` drop immediately, without waiting for a clock edge. The first grant after reset deassertion follows the IDLE rule.
- **No request**: all outputs are static; no state toggles.

## Configuration
- **ROUND_ROBIN_EN defined**
  - A 3-bit pointer starts at 0.
  - Search runs from the pointer upward with wrap (7 to 0); the first eligible bit wins.
  - On each grant to k, the pointer becomes (k+1) mod 8.
- **ROUND_ROBIN_EN undefined**
  - Fixed priority: the lowest eligible index wins (bit 0 highest).
  - No pointer register is built.
- Handshake, mask and timeout behave identically in both builds.

## Test plan
- **Basic grant/release**: reset, `req`=8'b0000_0100 held for 5 cycles then dropped.
  - `gnt`=8'b0000_0100 and `gnt_id`=2 one cycle after the request, held 5 cycles.
  - Then `gnt`=0 for 2 cycles; `timeout` never pulses.
- **Priority**: `req`=8'b1010_0010 held.
  - Fixed build: first grant goes to id 1.
  - ROUND_ROBIN_EN build: grants rotate 1, 5, 7, 1 as each tenure is dropped and re-requested.
- **Timeout**: MAX_HOLD=4, `req[3]` held continuously.
  - `gnt[3]` is high for exactly 4 cycles.
  - `timeout` pulses in the next cycle.
  - id 3 is not granted again until `req[3]` goes low for at least one cycle and then returns.
- **Starvation masking**: MAX_HOLD=4, `req`=8'b0000_1001 held, fixed build.
  - id 0 times out, then id 3 is granted.
  - id 0 is still masked after id 3 times out; `gnt` stays 0 while both requests stay high.
- **Coincident drop**: MAX_HOLD=4, `req[2]` drops in the 4th grant cycle.
  - No `timeout` pulse; `mask[2]` stays 0.
  - A re-request of id 2 is granted normally.
- **Async reset**: assert `rst` mid-tenure while `gnt`=8'b0100_0000.
  - `gnt`=0, `busy`=0, `gnt_id`=0 before the next clock edge.
  - After release of `rst` with `req[6]` still high, grant returns one cycle later.
